// File: rtl/eth_rx_mac.sv
// GMII receive MAC: preamble/SFD strip, CRC-32 and length check, little-endian word packing, RX irq.
// Optional DA filtering is compiled in with `define ETH_RX_MAC_FILTER_EN.
module eth_rx_mac #(
    parameter int ADDR_W  = 9,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic              i_rx_clk,
    input  logic              rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_dv,
    input  logic [47:0]       i_mac_addr,
    input  logic              i_rx_ack,
    output logic              o_buf_wr,
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic [31:0]       o_buf_data,
    output logic [10:0]       o_pkt_len,
    output logic              o_pkt_ok,
    output logic              o_irq_rx,
    output logic [15:0]       o_drop_cnt
);

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [10:0] LEN_LIMIT   = 11'(MAX_LEN + 1);
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);

    if (MAX_LEN >= 4 * (2 ** ADDR_W)) begin : g_len_check
        $error("eth_rx_mac: MAX_LEN does not fit in the packet buffer");
    end

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_END, S_DONE, S_DROP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       crc;
    logic [10:0]       cnt;
    logic [10:0]       cnt_inc;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       word;
    logic              busy_seen;
    logic              da_miss;
    logic              sfd;
    logic              take;
    logic              word_done;
    logic              flush;
    logic              drop_done;

    // Register is kept MSB-first while bits enter LSB-first, so the good-frame residue is C704DD7B.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    assign cnt_inc = cnt + 11'd1;

`ifdef ETH_RX_MAC_FILTER_EN
    logic [39:0] da_hist;
    logic [47:0] da_full;

    assign da_full = {da_hist, i_rx_data};
    assign da_miss = (cnt_inc == 11'd6) && (da_full != i_mac_addr) && (da_full != 48'hFFFF_FFFF_FFFF);

    always_ff @(posedge i_rx_clk) begin
        if (take) da_hist <= da_full[39:0];
    end
`else
    logic unused_mac;
    assign unused_mac = ^i_mac_addr;
    assign da_miss    = 1'b0;
`endif

    always_ff @(posedge i_rx_clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_rx_dv) state_nxt = (i_rx_data == 8'h55) ? S_PRE : S_DROP;
            S_PRE: begin
                if (!i_rx_dv)                state_nxt = S_IDLE;
                else if (i_rx_data == 8'hD5) state_nxt = S_DATA;
                else if (i_rx_data != 8'h55) state_nxt = S_DROP;
            end
            S_DATA: begin
                if (!i_rx_dv)                           state_nxt = S_END;
                else if (cnt_inc == LEN_LIMIT || da_miss) state_nxt = S_DROP;
            end
            S_END:  state_nxt = S_DONE;
            S_DONE: if (i_rx_ack) state_nxt = S_IDLE;
            S_DROP: if (!i_rx_dv) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sfd       = (state == S_PRE) && i_rx_dv && (i_rx_data == 8'hD5);
        take      = (state == S_DATA) && i_rx_dv;
        word_done = take && (cnt[1:0] == 2'd3);
        flush     = (state == S_END);
        // A frame ignored while DONE counts once, when its dv falls.
        drop_done = ((state == S_DROP) && !i_rx_dv) || ((state == S_DONE) && busy_seen && !i_rx_dv);
    end

    always_ff @(posedge i_rx_clk) begin
        if (!rst_n) begin
            o_buf_wr   <= 1'b0;
            o_buf_addr <= '0;
            o_buf_data <= '0;
            o_pkt_len  <= '0;
            o_pkt_ok   <= 1'b0;
            o_irq_rx   <= 1'b0;
            o_drop_cnt <= '0;
            crc        <= 32'hFFFF_FFFF;
            cnt        <= '0;
            idx        <= '0;
            busy_seen  <= 1'b0;
        end else begin
            o_buf_wr  <= 1'b0;
            busy_seen <= (state == S_DONE) && !i_rx_ack && i_rx_dv;
            if (sfd) begin
                crc  <= 32'hFFFF_FFFF;
                cnt  <= '0;
                idx  <= '0;
                word <= '0;
            end
            if (take) begin
                crc <= crc_next(crc, i_rx_data);
                cnt <= cnt_inc;
                if (word_done) begin
                    o_buf_wr   <= 1'b1;
                    o_buf_addr <= idx;
                    o_buf_data <= {i_rx_data, word[23:0]};
                    idx        <= idx + ADDR_W'(1);
                    word       <= '0;
                end else begin
                    word[{cnt[1:0], 3'b000} +: 8] <= i_rx_data;
                end
            end
            if (flush) begin
                o_buf_wr   <= (cnt[1:0] != 2'd0);
                o_buf_addr <= idx;
                o_buf_data <= word;
                o_pkt_len  <= cnt;
                o_pkt_ok   <= (crc == CRC_RESIDUE) && (cnt >= LEN_MIN);
                o_irq_rx   <= 1'b1;
            end
            if ((state == S_DONE) && i_rx_ack) o_irq_rx <= 1'b0;
            if (drop_done && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_rx_mac.sv
// Scoreboard bench for eth_rx_mac: expected buffer writes and frame status are queued when a
// frame is driven and compared as the DUT produces them.
module tb_eth_rx_mac;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_dv = 1'b0;
    logic [47:0]       mac = 48'h02_00_00_00_00_01;
    logic              rx_ack = 1'b0;
    logic              buf_wr;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
    logic [10:0]       pkt_len;
    logic              pkt_ok;
    logic              irq_rx;
    logic [15:0]       drop_cnt;

    eth_rx_mac #(.ADDR_W(ADDR_W), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .i_rx_clk   (clk),
        .rst_n      (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_dv    (rx_dv),
        .i_mac_addr (mac),
        .i_rx_ack   (rx_ack),
        .o_buf_wr   (buf_wr),
        .o_buf_addr (buf_addr),
        .o_buf_data (buf_data),
        .o_pkt_len  (pkt_len),
        .o_pkt_ok   (pkt_ok),
        .o_irq_rx   (irq_rx),
        .o_drop_cnt (drop_cnt)
    );

    always #4 clk = ~clk;

    int                n_chk = 0;
    int                n_pass = 0;
    int                exp_drop = 0;
    logic [7:0]        frm[$];
    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    logic [10:0]       sq_len[$];
    logic              sq_ok[$];
    logic              irq_q = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference FCS: standard reflected CRC-32, appended least-significant byte first.
    task automatic build_frame(input int len, input logic [47:0] da);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 14; i < len - 4; i++) frm.push_back(8'(i * 7 + 3));
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic expect_rx(input int n_taken, input bit complete, input bit ok);
        logic [31:0] w;
        for (int k = 0; 4 * k + 3 < n_taken; k++) begin
            wq_addr.push_back(ADDR_W'(k));
            wq_data.push_back({frm[4*k+3], frm[4*k+2], frm[4*k+1], frm[4*k]});
        end
        if (complete) begin
            if (n_taken % 4 != 0) begin
                w = '0;
                for (int j = 0; j < n_taken % 4; j++) w[8*j +: 8] = frm[4*(n_taken/4) + j];
                wq_addr.push_back(ADDR_W'(n_taken / 4));
                wq_data.push_back(w);
            end
            sq_len.push_back(11'(n_taken));
            sq_ok.push_back(ok);
        end
    endtask

    task automatic send(input int rst_at);
        int n;
        n = frm.size() + 8;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                chk("rst_mid_wr", 64'(buf_wr), 64'd0);
                chk("rst_mid_len", 64'(pkt_len), 64'd0);
                chk("rst_mid_ok", 64'(pkt_ok), 64'd0);
                chk("rst_mid_irq", 64'(irq_rx), 64'd0);
                chk("rst_mid_drop", 64'(drop_cnt), 64'd0);
            end
            rx_dv   = 1'b1;
            rx_data = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : frm[i-8];
            rst_n   = (i == rst_at) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        rst_n   = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (buf_wr) begin
            if (wq_addr.size() == 0) begin
                chk("wr_extra", 64'(wq_addr.size()), 64'd1);
            end else begin
                chk("wr_addr", 64'(buf_addr), 64'(wq_addr.pop_front()));
                chk("wr_data", 64'(buf_data), 64'(wq_data.pop_front()));
            end
        end
        if (irq_rx && !irq_q) begin
            if (sq_len.size() == 0) begin
                chk("irq_extra", 64'(sq_len.size()), 64'd1);
            end else begin
                chk("pkt_len", 64'(pkt_len), 64'(sq_len.pop_front()));
                chk("pkt_ok", 64'(pkt_ok), 64'(sq_ok.pop_front()));
            end
        end
        irq_q = irq_rx;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", 64'(buf_wr), 64'd0);
        chk("rst_addr", 64'(buf_addr), 64'd0);
        chk("rst_data", 64'(buf_data), 64'd0);
        chk("rst_len", 64'(pkt_len), 64'd0);
        chk("rst_ok", 64'(pkt_ok), 64'd0);
        chk("rst_irq", 64'(irq_rx), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Good 64- and 65-byte frames
        build_frame(64, mac); expect_rx(64, 1'b1, 1'b1); send(-1);
        chk("f64_irq", 64'(irq_rx), 64'd1);
        ack_pulse();
        chk("f64_irq_clr", 64'(irq_rx), 64'd0);
        build_frame(65, mac); expect_rx(65, 1'b1, 1'b1); send(-1);
        chk("f65_irq", 64'(irq_rx), 64'd1);
        ack_pulse();

        // Corrupted payload bit, then a frame arriving before ack
        build_frame(65, mac); frm[20] = frm[20] ^ 8'h04; expect_rx(65, 1'b1, 1'b0); send(-1);
        chk("bad_irq", 64'(irq_rx), 64'd1);
        chk("bad_drop", 64'(drop_cnt), 64'(exp_drop));
        build_frame(64, mac); send(-1);
        exp_drop++;
        chk("busy_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("busy_irq", 64'(irq_rx), 64'd1);
        ack_pulse();
        chk("busy_irq_clr", 64'(irq_rx), 64'd0);
        build_frame(64, mac); expect_rx(64, 1'b1, 1'b1); send(-1);
        chk("third_irq", 64'(irq_rx), 64'd1);
        ack_pulse();

        // Oversize and undersize frames
        build_frame(1600, mac); expect_rx(1519, 1'b0, 1'b0); send(-1);
        exp_drop++;
        chk("long_irq", 64'(irq_rx), 64'd0);
        chk("long_drop", 64'(drop_cnt), 64'(exp_drop));
        build_frame(60, mac); expect_rx(60, 1'b1, 1'b0); send(-1);
        chk("short_irq", 64'(irq_rx), 64'd1);
        chk("short_drop", 64'(drop_cnt), 64'(exp_drop));
        ack_pulse();

`ifdef ETH_RX_MAC_FILTER_EN
        build_frame(64, 48'hFFFF_FFFF_FFFF); expect_rx(64, 1'b1, 1'b1); send(-1);
        chk("bcast_irq", 64'(irq_rx), 64'd1);
        ack_pulse();
        build_frame(64, 48'h02_00_00_00_00_02); expect_rx(6, 1'b0, 1'b0); send(-1);
        exp_drop++;
        chk("filt_irq", 64'(irq_rx), 64'd0);
        chk("filt_drop", 64'(drop_cnt), 64'(exp_drop));
`endif

        // Reset pulse on stream byte 30; the tail must be dropped as a fresh frame
        build_frame(64, mac); frm[23] = 8'hA5; expect_rx(22, 1'b0, 1'b0); send(30);
        exp_drop = 1;
        chk("rst_tail_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("rst_tail_irq", 64'(irq_rx), 64'd0);
        build_frame(64, mac); expect_rx(64, 1'b1, 1'b1); send(-1);
        chk("post_rst_irq", 64'(irq_rx), 64'd1);
        chk("post_rst_drop", 64'(drop_cnt), 64'(exp_drop));
        ack_pulse();

        chk("wr_missing", 64'(wq_addr.size()), 64'd0);
        chk("status_missing", 64'(sq_len.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
